// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  // Operation codes as presented on the op port.
  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  // Supported multiply latency range.
  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 8;

  // Pull an out-of-range latency back into the supported window.
  function automatic int clamp_mul_lat(input int lat);
    if (lat < MUL_LAT_MIN) return MUL_LAT_MIN;
    if (lat > MUL_LAT_MAX) return MUL_LAT_MAX;
    return lat;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it did not go negative.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; the extra top bit of diff is the borrow.
  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, dvs};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit. Multiply waits a fixed latency on the
// captured operands; divide runs a prep cycle, WIDTH restoring steps and a
// sign fix-up cycle before presenting the result.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int LAT = clamp_mul_lat(MUL_LAT);
  // Counter must reach WIDTH+1 for divide and LAT-1 for multiply.
  localparam int CW  = ($clog2(WIDTH + 2) > 4) ? $clog2(WIDTH + 2) : 4;
  localparam logic [CW-1:0] MUL_LAST = CW'(LAT - 1);
  localparam logic [CW-1:0] DIV_FIX  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] DIV_STEP = CW'(WIDTH);

  mdu_state_e       state_reg, state_next;
  mdu_op_e          op_reg, op_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;

  logic             accept;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             mul_signed;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0] rem_step;
  logic             q_step;

  mdu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_reg),
    .bit_in (quo_reg[WIDTH-1]),
    .dvs    (dvs_reg),
    .rem_out(rem_step),
    .q_bit  (q_step)
  );

  // Operand conditioning: magnitudes for signed divide, extended operands
  // for a 2*WIDTH product (sign extension makes the low 2*WIDTH bits exact).
  always_comb begin
    a_neg      = (op_reg == MDU_DIV) && a_reg[WIDTH-1];
    b_neg      = (op_reg == MDU_DIV) && b_reg[WIDTH-1];
    a_mag      = a_neg ? -a_reg : a_reg;
    b_mag      = b_neg ? -b_reg : b_reg;
    mul_signed = (op_reg == MDU_MULT);
    a_ext      = {{WIDTH{mul_signed & a_reg[WIDTH-1]}}, a_reg};
    b_ext      = {{WIDTH{mul_signed & b_reg[WIDTH-1]}}, b_reg};
    prod       = a_ext * b_ext;
  end

  // Next-state and datapath updates; hi/lo only move when entering DONE.
  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    rem_next   = rem_reg;
    quo_next   = quo_reg;
    dvs_next   = dvs_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    accept     = start && !cancel &&
                 ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        state_next = ST_IDLE;
        if (accept) begin
          op_next    = mdu_op_e'(op);
          a_next     = a;
          b_next     = b;
          cnt_next   = '0;
          state_next = op[1] ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL: begin
        if (cancel) begin
          state_next = ST_IDLE;
        end else if (cnt_reg == MUL_LAST) begin
          state_next = ST_DONE;
          hi_next    = prod[2*WIDTH-1:WIDTH];
          lo_next    = prod[WIDTH-1:0];
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_DIV: begin
        if (cancel) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_reg == '0) begin
            rem_next = '0;
            quo_next = a_mag;
            dvs_next = b_mag;
          end else if (cnt_reg <= DIV_STEP) begin
            rem_next = rem_step;
            quo_next = {quo_reg[WIDTH-2:0], q_step};
          end else if (cnt_reg == DIV_FIX) begin
            state_next = ST_DONE;
            if (b_reg == '0) begin
              // Divide by zero: fixed pattern, dividend passed through raw.
              lo_next = '1;
              hi_next = a_reg;
            end else begin
              lo_next = (a_neg ^ b_neg) ? -quo_reg : quo_reg;
              hi_next = a_neg ? -rem_reg : rem_reg;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      op_reg    <= MDU_MULT;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      dvs_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      rem_reg   <= rem_next;
      quo_reg   <= quo_next;
      dvs_reg   <= dvs_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = (state_reg == ST_MUL) || (state_reg == ST_DIV);
    done = (state_reg == ST_DONE);
    hi   = hi_reg;
    lo   = lo_reg;
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_mdu_iter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, cancel;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, busy1, done1, busy4, done4;
  logic [W-1:0] hi, lo, hi1, lo1, hi4, lo4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W), .MUL_LAT(2)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo));

  mdu_iter #(.WIDTH(W), .MUL_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

  mdu_iter #(.WIDTH(W), .MUL_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy4), .done(done4), .hi(hi4), .lo(lo4));

  // Reference result {hi, lo} from plain arithmetic.
  function automatic logic [63:0] ref_mdu(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
    longint sp;
    int q, r;
    case (o)
      2'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      2'd1: return {32'h0, x} * {32'h0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Present one start pulse; returns at the negedge just after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
  endtask

  // Count negedges until done (cyc = -1 on timeout) and busy cycles seen.
  task automatic wait_done(output int cyc, output int bcnt);
    int n;
    n = 0; cyc = -1; bcnt = 0;
    while (cyc < 0 && n < 100) begin
      if (done === 1'b1) cyc = n;
      else begin
        if (busy === 1'b1) bcnt++;
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (hi !== '0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi); end
    total++; if (lo !== '0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_release busy=%b done=%b exp=0/0", busy, done);
    end
  endtask

  task automatic test_mult;
    int cyc, bc;
    issue(2'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(cyc, bc);
    total++; if (cyc != 2) begin bad++; $display("FAIL mult_latency got=%0d exp=2", cyc); end
    total++; if (bc != 2) begin bad++; $display("FAIL mult_busy got=%0d exp=2", bc); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
    total++; if (lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo got=%h exp=fffffffa", lo); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL mult_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mul_latency;
    int d1, d2, d4;
    repeat (6) @(negedge clk);
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    d1 = -1; d2 = -1; d4 = -1;
    for (int n = 0; n < 10; n++) begin
      if (d1 < 0 && done1 === 1'b1) d1 = n;
      if (d2 < 0 && done  === 1'b1) d2 = n;
      if (d4 < 0 && done4 === 1'b1) d4 = n;
      @(negedge clk);
    end
    total++; if (d1 != 1) begin bad++; $display("FAIL lat1_done got=%0d exp=1", d1); end
    total++; if (d2 != 2) begin bad++; $display("FAIL lat2_done got=%0d exp=2", d2); end
    total++; if (d4 != 4) begin bad++; $display("FAIL lat4_done got=%0d exp=4", d4); end
    total++; if ({hi1, lo1} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL lat1_result got=%h_%h exp=fffffffe_00000001", hi1, lo1);
    end
    total++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL multu_result got=%h_%h exp=fffffffe_00000001", hi, lo);
    end
    total++; if ({hi4, lo4} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL lat4_result got=%h_%h exp=fffffffe_00000001", hi4, lo4);
    end
  endtask

  task automatic test_div;
    int cyc, bc;
    issue(2'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, bc);
    total++; if (cyc != 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", cyc); end
    total++; if (bc != 34) begin bad++; $display("FAIL div_busy got=%0d exp=34", bc); end
    total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
    total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end
    issue(2'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc, bc);
    total++; if (cyc != 34) begin bad++; $display("FAIL divu_latency got=%0d exp=34", cyc); end
    total++; if (lo !== 32'h7FFF_FFFC) begin bad++; $display("FAIL divu_lo got=%h exp=7ffffffc", lo); end
    total++; if (hi !== 32'h0000_0001) begin bad++; $display("FAIL divu_hi got=%h exp=00000001", hi); end
  endtask

  task automatic test_div_corner;
    int cyc, bc;
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc, bc);
    total++; if ({hi, lo} !== 64'h0000_0000_8000_0000) begin
      bad++; $display("FAIL div_ovf got=%h_%h exp=00000000_80000000", hi, lo);
    end
    issue(2'd3, 32'd5, 32'd0);
    wait_done(cyc, bc);
    total++; if (cyc != 34) begin bad++; $display("FAIL divu_zero_latency got=%0d exp=34", cyc); end
    total++; if ({hi, lo} !== 64'h0000_0005_FFFF_FFFF) begin
      bad++; $display("FAIL divu_zero got=%h_%h exp=00000005_ffffffff", hi, lo);
    end
    issue(2'd2, 32'hFFFF_FFF9, 32'd0);
    wait_done(cyc, bc);
    total++; if ({hi, lo} !== 64'hFFFF_FFF9_FFFF_FFFF) begin
      bad++; $display("FAIL div_zero_raw got=%h_%h exp=fffffff9_ffffffff", hi, lo);
    end
  endtask

  task automatic test_busy_ignore;
    int cyc, bc;
    issue(2'd2, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bc);
    total++; if (cyc != 28) begin bad++; $display("FAIL ignore_latency got=%0d exp=28", cyc); end
    total++; if ({hi, lo} !== 64'h0000_0002_0000_000E) begin
      bad++; $display("FAIL ignore_result got=%h_%h exp=00000002_0000000e", hi, lo);
    end
  endtask

  task automatic test_cancel;
    int seen;
    issue(2'd2, $urandom, 32'd9);
    repeat (10) @(negedge clk);
    cancel = 1'b1; start = 1'b1; op = 2'd1; a = $urandom; b = $urandom;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL cancel_drop busy=%b done=%b exp=0/0", busy, done);
    end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL cancel_quiet active=%0d exp=0", seen); end
    total++; if ({hi, lo} !== 64'h0000_0002_0000_000E) begin
      bad++; $display("FAIL cancel_hold got=%h_%h exp=00000002_0000000e", hi, lo);
    end
  endtask

  task automatic test_back_to_back;
    int cyc, bc;
    logic [31:0] x1, y1, x2, y2;
    logic [63:0] e1, e2;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = $urandom_range(1, 1000);
    e1 = ref_mdu(2'd0, x1, y1);
    e2 = ref_mdu(2'd3, x2, y2);
    issue(2'd0, x1, y1);
    wait_done(cyc, bc);
    total++; if ({hi, lo} !== e1) begin bad++; $display("FAIL b2b_first got=%h_%h exp=%h", hi, lo, e1); end
    start = 1'b1; op = 2'd3; a = x2; b = y2;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    total++; if (done !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept done=%b busy=%b exp=0/1", done, busy);
    end
    total++; if ({hi, lo} !== e1) begin bad++; $display("FAIL b2b_hold got=%h_%h exp=%h", hi, lo, e1); end
    wait_done(cyc, bc);
    total++; if (cyc != 34) begin bad++; $display("FAIL b2b_latency got=%0d exp=34", cyc); end
    total++; if ({hi, lo} !== e2) begin bad++; $display("FAIL b2b_second got=%h_%h exp=%h", hi, lo, e2); end
  endtask

  task automatic test_reset_mid;
    int cyc, bc, seen;
    issue(2'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(cyc, bc);
    issue(2'd2, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctrl busy=%b done=%b exp=0/0", busy, done);
    end
    total++; if ({hi, lo} !== 64'h0) begin bad++; $display("FAIL rstmid_data got=%h_%h exp=0_0", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_quiet active=%0d exp=0", seen); end
  endtask

  task automatic test_random;
    int cyc, bc, exp_cyc;
    logic [1:0] o;
    logic [31:0] x, y;
    logic [63:0] e;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: y = -$urandom_range(1, 15);
        3: x = 32'h8000_0000;
        default: ;
      endcase
      e = ref_mdu(o, x, y);
      exp_cyc = o[1] ? 34 : 2;
      issue(o, x, y);
      wait_done(cyc, bc);
      $display("txn op=%0d a=%h b=%h hi=%h lo=%h cyc=%0d", o, x, y, hi, lo, cyc);
      total++; if (cyc != exp_cyc) begin
        bad++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, cyc, exp_cyc);
      end
      total++; if ({hi, lo} !== e) begin
        bad++; $display("FAIL rand_result[%0d] got=%h_%h exp=%h", i, hi, lo, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mul_latency();
    test_div();
    test_div_corner();
    test_busy_ignore();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
